// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the device, then shifts one command byte out on device clocks.
// Optional macro PS2_TX_RETRY_EN: one silent retry of a failed byte before err is reported.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);
   localparam int unsigned MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [1:0] CODE_TIMEOUT = 2'b01;
   localparam logic [1:0] CODE_NOACK   = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_RELEASE, S_SHIFT, S_WAIT_IDLE, S_DONE, S_ERR
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       data_q, data_d;
   logic             par_q, par_d;
   logic             sdat_q, sdat_d;
   logic [1:0]       code_d;
   logic             clk_oe_d, dat_oe_d;
   logic             clk_meta, clk_sync, clk_prev, dat_meta, dat_sync;
   logic             fe_c, accept_c, wd_exp_c, fail_c, retry_ok_c;
   logic [1:0]       fail_code_c;

   assign fe_c     = clk_prev & ~clk_sync;
   assign accept_c = tx_valid & tx_ready;
   assign wd_exp_c = (cnt_q == TO_LIMIT);

   // Two-flop synchronizers plus a delayed copy of the clock for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta <= 1'b1;
         clk_sync <= 1'b1;
         clk_prev <= 1'b1;
         dat_meta <= 1'b1;
         dat_sync <= 1'b1;
      end else begin
         clk_meta <= ps2_clk_in;
         clk_sync <= clk_meta;
         clk_prev <= clk_sync;
         dat_meta <= ps2_dat_in;
         dat_sync <= dat_meta;
      end
   end

`ifdef PS2_TX_RETRY_EN
   logic retry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         retry_q <= 1'b0;
      end else if (accept_c) begin
         retry_q <= 1'b0;
      end else if (fail_c) begin
         retry_q <= 1'b1;
      end
   end

   assign retry_ok_c = ~retry_q;
`else
   assign retry_ok_c = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      data_d      = data_q;
      par_d       = par_q;
      sdat_d      = sdat_q;
      code_d      = err_code;
      fail_c      = 1'b0;
      fail_code_c = CODE_TIMEOUT;
      clk_oe_d    = 1'b0;
      dat_oe_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               data_d  = tx_data;
               par_d   = ~^tx_data;
               cnt_d   = '0;
               state_d = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               state_d = S_REQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_REQ: begin
            state_d = S_RELEASE;
            cnt_d   = '0;
            bit_d   = '0;
            sdat_d  = 1'b1;
         end
         S_RELEASE: begin
            if (wd_exp_c) begin
               fail_c = 1'b1;
            end else begin
               state_d = S_SHIFT;
               cnt_d   = fe_c ? '0 : cnt_q + CNT_W'(1);
            end
         end
         S_SHIFT: begin
            if (wd_exp_c) begin
               fail_c = 1'b1;
            end else if (fe_c) begin
               // bit_q counts falling edges already seen: 0..7 data, 8 parity, 9 stop, 10 ack
               cnt_d = '0;
               bit_d = bit_q + 4'd1;
               if (bit_q < 4'd8) begin
                  sdat_d = ~data_q[bit_q[2:0]];
               end else if (bit_q == 4'd8) begin
                  sdat_d = ~par_q;
               end else if (bit_q == 4'd9) begin
                  sdat_d = 1'b0;
               end else if (dat_sync) begin
                  fail_c      = 1'b1;
                  fail_code_c = CODE_NOACK;
               end else begin
                  state_d = S_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_IDLE: begin
            if (wd_exp_c) begin
               fail_c = 1'b1;
            end else if (clk_sync && dat_sync) begin
               state_d = S_DONE;
            end else begin
               cnt_d = fe_c ? '0 : cnt_q + CNT_W'(1);
            end
         end
         S_DONE, S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fail_c) begin
         cnt_d = '0;
         if (retry_ok_c) begin
            state_d = S_INHIBIT;
         end else begin
            state_d = S_ERR;
            code_d  = fail_code_c;
         end
      end

      // Line drives are registered from the state being entered
      clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_REQ);
      case (state_d)
         S_REQ, S_RELEASE: dat_oe_d = 1'b1;
         S_SHIFT:          dat_oe_d = sdat_d;
         default:          dat_oe_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         par_q      <= 1'b0;
         sdat_q     <= 1'b0;
         tx_ready   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'b00;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         par_q      <= par_d;
         sdat_q     <= sdat_d;
         tx_ready   <= (state_d == S_IDLE);
         busy       <= (state_d != S_IDLE);
         done       <= (state_d == S_DONE);
         err        <= (state_d == S_ERR);
         err_code   <= code_d;
         ps2_clk_oe <= clk_oe_d;
         ps2_dat_oe <= dat_oe_d;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT, a scoreboard holds expected outcomes.
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int unsigned INH   = 40;
   localparam int unsigned TO    = 3000;
   localparam int          HALF  = 8;
   localparam int          LIMIT = 4 * TO + 4000;
`ifdef PS2_TX_RETRY_EN
   localparam int FAIL_FRAMES = 2;
`else
   localparam int FAIL_FRAMES = 1;
`endif

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic [1:0] code;
      int         frames0;
      int         errs0;
      int         dones0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, busy, done, err;
   logic [1:0] err_code;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       line_clk, line_dat;
   logic       dev_clk_low = 1'b0;
   logic       dev_dat_low = 1'b0;
   logic       dev_ack = 1'b1;
   logic       dev_abort = 1'b0;
   int         dev_stop_after = 11;
   int         dev_frames = 0;
   int         dev_nfe = 0;
   logic [10:0] dev_bits = '1;
   time        dev_fe_t = 0;
   time        t_pulse = 0;
   int         err_pulses = 0;
   int         done_pulses = 0;
   int         inh_run = 0, last_inh = 0, req_run = 0, last_req = 0;
   int         errors = 0;
   int         checks = 0;
   exp_t       sb[$];

   assign line_clk = ~(ps2_clk_oe | dev_clk_low);
   assign line_dat = ~(ps2_dat_oe | dev_dat_low);

   always #5 clk = ~clk;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
      .ps2_clk_in(line_clk), .ps2_dat_in(line_dat),
      .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
   );

   // Device model: starts clocking when the host releases the clock after its request
   initial begin : device
      logic prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (prev && !ps2_clk_oe && ps2_dat_oe && !rst) begin
            dev_frames++;
            dev_nfe  = 0;
            dev_bits = '1;
            repeat (HALF) @(negedge clk);
            dev_bits[0] = line_dat;
            for (int k = 1; k <= dev_stop_after; k++) begin
               if (dev_abort) break;
               dev_clk_low = 1'b1;
               if (k == 11 && dev_ack) dev_dat_low = 1'b1;
               dev_nfe  = k;
               dev_fe_t = $time;
               repeat (HALF) @(negedge clk);
               if (k <= 10) dev_bits[k] = line_dat;
               dev_clk_low = 1'b0;
               repeat (HALF) @(negedge clk);
               dev_dat_low = 1'b0;
            end
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            prev = 1'b0;
         end else begin
            prev = ps2_clk_oe;
         end
      end
   end

   always @(negedge clk) begin
      if (err) err_pulses++;
      if (done) done_pulses++;
      if (ps2_clk_oe && !ps2_dat_oe) inh_run++;
      else begin
         if (inh_run != 0) last_inh = inh_run;
         inh_run = 0;
      end
      if (ps2_clk_oe && ps2_dat_oe) req_run++;
      else begin
         if (req_run != 0) last_req = req_run;
         req_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic ack, input int stop_after, input logic [1:0] code);
      exp_t e;
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) if (d[i]) ones++;
      e.data    = d;
      e.par     = (ones % 2 == 0);
      e.code    = code;
      e.frames0 = dev_frames;
      e.errs0   = err_pulses;
      e.dones0  = done_pulses;
      sb.push_back(e);
      dev_ack        = ack;
      dev_stop_after = stop_after;
      check("ready_before_send", 32'(tx_ready), 32'd1);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      check("busy_after_accept", 32'(busy), 32'd1);
   endtask

   task automatic finish_txn(input string tag);
      exp_t e;
      logic seen;
      int   nframes;
      e    = sb.pop_front();
      seen = 1'b0;
      for (int n = 0; n < LIMIT; n++) begin
         @(negedge clk);
         if (done || err) begin
            seen = 1'b1;
            break;
         end
      end
      t_pulse = $time;
      check({tag, "_completes"}, 32'(seen), 32'd1);
      check({tag, "_done_err"}, 32'({done, err}), 32'({e.code == 2'b00, e.code != 2'b00}));
      if (e.code != 2'b00) check({tag, "_err_code"}, 32'(err_code), 32'(e.code));
      check({tag, "_lines_released"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check({tag, "_busy_in_pulse"}, 32'(busy), 32'd1);
      if (e.code != 2'b01) begin
         check({tag, "_byte"}, 32'(dev_bits[8:1]), 32'(e.data));
         check({tag, "_parity"}, 32'(dev_bits[9]), 32'(e.par));
         check({tag, "_start_stop"}, 32'({dev_bits[10], dev_bits[0]}), 32'(2'b10));
      end
      nframes = (e.code == 2'b00) ? 1 : FAIL_FRAMES;
      check({tag, "_frames"}, 32'(dev_frames - e.frames0), 32'(nframes));
      if (e.code == 2'b00) check({tag, "_no_err"}, 32'(err_pulses), 32'(e.errs0));
      @(negedge clk);
      check({tag, "_after_pulse"}, 32'({done, err, busy, tx_ready}), 32'(4'b0001));
   endtask

   initial begin
      exp_t ab;
      logic seen;
      int   f0;
      longint delta;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done_err", 32'({done, err}), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      send(8'hED, 1'b1, 11, 2'b00);
      finish_txn("ed");
      check("inhibit_len", 32'(last_inh), INH);
      check("req_len", 32'(last_req), 32'd1);

      send(8'h01, 1'b1, 11, 2'b00);
      finish_txn("x01");

      send(8'hFF, 1'b0, 11, 2'b10);
      finish_txn("ff_noack");

      // 0x55 offered while the 0xF4 frame is in progress must be dropped
      send(8'hF4, 1'b1, 11, 2'b00);
      repeat (5) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      check("busy_ready_low", 32'({busy, tx_ready}), 32'(2'b10));
      repeat (10) @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      finish_txn("f4");
      check("err_code_holds", 32'(err_code), 32'(2'b10));
      f0 = dev_frames;
      repeat (100) @(negedge clk);
      check("no_extra_frame", 32'(dev_frames), 32'(f0));
      check("idle_after_f4", 32'({busy, tx_ready}), 32'(2'b01));

      send(8'h5A, 1'b1, 4, 2'b01);
      finish_txn("timeout");
      delta = longint'((t_pulse - dev_fe_t) / 10);
      check("timeout_delay_in_window", 32'((delta >= longint'(TO + 2)) && (delta <= longint'(TO + 6))), 32'd1);

      // Reset in the middle of a frame, then a clean frame
      send(8'hA5, 1'b1, 11, 2'b00);
      ab   = sb.pop_front();
      seen = 1'b0;
      for (int n = 0; n < LIMIT; n++) begin
         @(negedge clk);
         if (dev_frames != ab.frames0 && dev_nfe == 6) begin
            seen = 1'b1;
            break;
         end
      end
      check("reach_fe6", 32'(seen), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("midrst_ready_busy", 32'({tx_ready, busy}), 32'(2'b10));
      check("midrst_err_code", 32'(err_code), 32'd0);
      rst       = 1'b0;
      dev_abort = 1'b1;
      repeat (40) @(negedge clk);
      dev_abort = 1'b0;
      check("aborted_no_pulse", 32'({done_pulses - ab.dones0, err_pulses - ab.errs0}), 32'd0);
      send(8'h3C, 1'b1, 11, 2'b00);
      finish_txn("after_rst");
      check("err_code_cleared", 32'(err_code), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
